// File: rtl/seg7_scan_animator_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_animator_if
// Character handshake between a producer and the seg7_scan_animator.
//   char_valid  producer -> display  a segment pattern is offered on char_in
//   char_in     producer -> display  raw pattern {g,f,e,d,c,b,a}, 1 = lit
//   char_ready  display  -> producer the display accepts char_in this cycle
// A character transfers on any rising clock edge where valid and ready are
// both high.
// Modports: master (producer side), slave (display side).
// ---------------------------------------------------------------------------
interface seg7_scan_animator_if;
  logic       char_valid;
  logic [6:0] char_in;
  logic       char_ready;

  modport master (output char_valid, output char_in, input char_ready);
  modport slave  (input char_valid, input char_in, output char_ready);
endinterface

// File: rtl/seg7_scan_animator.sv
// ---------------------------------------------------------------------------
// seg7_scan_animator
// Multi-digit multiplexed 7-segment engine. Incoming characters shift in from
// the right (digit 0), the digits are scanned one at a time onto a shared
// segment bus, and the lit segments are gated by a PWM brightness control.
//
// Optional feature, macro SEG7_SCAN_ANIM_EN:
//   defined   - each accepted character is revealed on digit 0 by a 7-step
//               segment wipe lasting 7*ANIM_DIV cycles; char_ready is low and
//               busy is high for the duration.
//   undefined - no animation; characters show in full immediately and
//               char_ready simply follows en.
//
// Ports:
//   clk         clock for all logic
//   rst_n       asynchronous active-low reset
//   en          block enable; low freezes all state and blanks the outputs
//   bus         slave side of the character handshake (char_valid/char_in/
//               char_ready)
//   clr         synchronous clear of the digit buffer (wins over an accept)
//   brightness  PWM on-count, sampled at the start of each PWM period
//   seg         registered segment drive, active high
//   dig_sel     registered one-hot digit select, active high
//   busy        wipe animation in progress
// ---------------------------------------------------------------------------
module seg7_scan_animator #(
  parameter int DIGITS   = 4,
  parameter int PWM_BITS = 8,
  parameter int SCAN_DIV = 1024,
  parameter int ANIM_DIV = 65536
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  seg7_scan_animator_if.slave     bus,
  input  logic                    clr,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [6:0]              seg,
  output logic [DIGITS-1:0]       dig_sel,
  output logic                    busy
);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [6:0]          disp [DIGITS];
  logic [IDX_W-1:0]    idx_reg;
  logic [SCAN_W-1:0]   scan_cnt_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [PWM_BITS-1:0] bright_reg;
  logic [6:0]          mask;
  logic [6:0]          shown;
  logic                pwm_on;
  logic                accept;
  logic                clr_en;

  // While disabled nothing may change, a pending clear included.
  assign clr_en = en & clr;
  assign accept = bus.char_valid & bus.char_ready & ~clr;

`ifdef SEG7_SCAN_ANIM_EN
  localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);

  typedef enum logic {IDLE, ANIM} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        step_reg, step_next;
  logic [ANIM_W-1:0] tmr_reg, tmr_next;

  assign bus.char_ready = en & (state_reg == IDLE);
  assign busy           = (state_reg == ANIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      tmr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      tmr_reg   <= tmr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    tmr_next   = tmr_reg;
    if (clr_en) begin
      state_next = IDLE;
      step_next  = '0;
      tmr_next   = '0;
    end else if (en) begin
      if (state_reg == IDLE) begin
        if (accept) begin
          state_next = ANIM;
          step_next  = '0;
          tmr_next   = '0;
        end
      end else begin
        if (tmr_reg == ANIM_LAST) begin
          tmr_next = '0;
          // Step 6 reveals the last segment; its wrap ends the wipe.
          if (step_reg == 3'd6) begin
            state_next = IDLE;
            step_next  = '0;
          end else begin
            step_next = step_reg + 3'd1;
          end
        end else begin
          tmr_next = tmr_reg + ANIM_W'(1);
        end
      end
    end
  end

  // Lowest (step+1) segment bits enabled: 01, 03, ... 7F.
  always_comb begin
    mask = 7'h7F;
    if (state_reg == ANIM) mask = 7'((8'd2 << step_reg) - 8'd1);
  end
`else
  assign bus.char_ready = en;
  assign busy           = 1'b0;
  assign mask           = 7'h7F;

  // ANIM_DIV only sizes the wipe step timer, which this build leaves out.
  if (ANIM_DIV < 1) begin : g_anim_div_unused
  end
`endif

  // Digit buffer: one register per digit, shifting left on every accept.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [6:0] cell_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)      cell_reg <= '0;
          else if (clr_en) cell_reg <= '0;
          else if (accept) cell_reg <= bus.char_in;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)      cell_reg <= '0;
          else if (clr_en) cell_reg <= '0;
          else if (accept) cell_reg <= disp[gi-1];
        end
      end
      assign disp[gi] = cell_reg;
    end
  endgenerate

  // Only the rightmost digit is subject to the wipe.
  assign shown  = disp[idx_reg] & ((idx_reg == '0) ? mask : 7'h7F);
  assign pwm_on = (pwm_cnt_reg < bright_reg);

  // Scan, PWM and output registers. Outputs are built from the current
  // index, so they trail the index by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg      <= '0;
      scan_cnt_reg <= '0;
      pwm_cnt_reg  <= '0;
      bright_reg   <= '0;
      seg          <= '0;
      dig_sel      <= '0;
    end else if (en) begin
      if (scan_cnt_reg == SCAN_LAST) begin
        scan_cnt_reg <= '0;
        idx_reg      <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
      end
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
      // Sampling only at period start keeps each PWM period glitch-free.
      if (pwm_cnt_reg == '0) bright_reg <= brightness;
      dig_sel <= DIGITS'(1) << idx_reg;
      seg     <= pwm_on ? shown : 7'h00;
    end else begin
      seg     <= '0;
      dig_sel <= '0;
    end
  end
endmodule

// File: tb/tb_seg7_scan_animator.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_animator
// Directed bench for seg7_scan_animator with DIGITS=4, PWM_BITS=4,
// SCAN_DIV=4, ANIM_DIV=2. Expectations for the wipe depend on whether
// SEG7_SCAN_ANIM_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_seg7_scan_animator;
  localparam int DIGITS   = 4;
  localparam int PWM_BITS = 4;
  localparam int SCAN_DIV = 4;
  localparam int ANIM_DIV = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                clr = 1'b0;
  logic [PWM_BITS-1:0] brightness = '0;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   dig_sel;
  logic                busy;

  int passed = 0;
  int total  = 0;
  int edge_k = 0;   // enabled clock edges since reset release

  logic [6:0] model_disp [DIGITS];
  logic [7:0] exp_q [$];

  seg7_scan_animator_if bus ();

  seg7_scan_animator #(
    .DIGITS   (DIGITS),
    .PWM_BITS (PWM_BITS),
    .SCAN_DIV (SCAN_DIV),
    .ANIM_DIV (ANIM_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus),
    .clr        (clr),
    .brightness (brightness),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)  edge_k <= 0;
    else if (en) edge_k <= edge_k + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

`ifdef SEG7_SCAN_ANIM_EN
  logic [6:0] mask_tab [7] = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F};

  // PWM gate for the output produced at enabled edge k, brightness b held
  // constant since reset release (latch is 0 for the very first edge).
  function automatic bit pwm_on_ref(input int k, input int b);
    return (k >= 2) && (((k - 1) % 16) < b);
  endfunction
`endif

  task automatic wait_ready(input string tag);
    int g = 0;
    while (bus.char_ready !== 1'b1 && g < 64) begin
      @(negedge clk);
      g++;
    end
    check(tag, 8'(g < 64), 8'd1);
  endtask

  // Offer one character and update the reference buffer.
  task automatic send(input logic [6:0] ch);
    wait_ready("ready_before_send");
    bus.char_in    = ch;
    bus.char_valid = 1'b1;
    @(negedge clk);
    bus.char_valid = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) model_disp[i] = model_disp[i-1];
    model_disp[0] = ch;
`ifdef SEG7_SCAN_ANIM_EN
    check("busy_after_send", 8'(busy), 8'd1);
`else
    check("ready_held_high", 8'(bus.char_ready), 8'd1);
`endif
  endtask

  // OR of seg over one complete select window of digit d.
  task automatic read_digit(input int d, output logic [6:0] val);
    logic [3:0] tgt;
    int g = 0;
    tgt = 4'b0001 << d;
    val = '0;
    while (dig_sel === tgt && g < 64) begin @(negedge clk); g++; end
    while (dig_sel !== tgt && g < 64) begin @(negedge clk); g++; end
    while (dig_sel === tgt && g < 64) begin
      val = val | seg;
      @(negedge clk);
      g++;
    end
    check("read_window", 8'(g < 64), 8'd1);
  endtask

  task automatic check_buffer();
    logic [6:0] v;
    for (int d = 0; d < DIGITS; d++) exp_q.push_back(8'(model_disp[d]));
    for (int d = 0; d < DIGITS; d++) begin
      read_digit(d, v);
      check($sformatf("digit%0d", d), 8'(v), exp_q.pop_front());
    end
  endtask

  initial begin
    int nz;
    bus.char_valid = 1'b0;
    bus.char_in    = '0;
    for (int i = 0; i < DIGITS; i++) model_disp[i] = '0;

    // Reset state
    en         = 1'b1;
    brightness = 4'd15;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", 8'(seg), 8'h00);
    check("rst_dig_sel", 8'(dig_sel), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_ready", 8'(bus.char_ready), 8'h01);

    // Scan sequence with an empty buffer
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(4'b0001 << ((i / SCAN_DIV) % DIGITS)));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("scan_dig_sel", 8'(dig_sel), exp_q.pop_front());
      check("scan_seg_dark", 8'(seg), 8'h00);
    end

    // First character: wipe on digit 0
`ifdef SEG7_SCAN_ANIM_EN
    begin
      int low, n_wipe, g;
      bit done;
      logic [6:0] exp_seg;
      // Align the accept so digit 0 is scanned during the first two steps.
      g = 0;
      while ((edge_k % 16) != 15 && g < 64) begin @(negedge clk); g++; end
      check("align_wait", 8'(g < 64), 8'd1);
      bus.char_in    = 7'h3F;
      bus.char_valid = 1'b1;
      @(negedge clk);
      bus.char_valid = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) model_disp[i] = model_disp[i-1];
      model_disp[0] = 7'h3F;
      check("anim_busy", 8'(busy), 8'd1);
      low = 0; n_wipe = 0; done = 1'b0;
      for (int m = 0; m < 40 && !done; m++) begin
        if (m >= 1 && dig_sel === 4'b0001) begin
          exp_seg = (m - 1 < 7 * ANIM_DIV) ? (7'h3F & mask_tab[(m - 1) / ANIM_DIV]) : 7'h3F;
          if (!pwm_on_ref(edge_k, 15)) exp_seg = 7'h00;
          check("wipe_seg", 8'(seg), 8'(exp_seg));
          n_wipe++;
        end
        if (bus.char_ready === 1'b1) done = 1'b1;
        else begin
          low++;
          @(negedge clk);
        end
      end
      check("anim_ready_low_cycles", 8'(low), 8'd14);
      check("anim_busy_done", 8'(busy), 8'd0);
      check("wipe_samples", 8'(n_wipe), 8'd4);
    end
`else
    send(7'h3F);
    check("no_anim_busy", 8'(busy), 8'd0);
`endif
    check_buffer();

    // Character sequence
    send(7'h06);
    send(7'h5B);
    send(7'h4F);
    send(7'h66);
    send(7'h6D);
    wait_ready("ready_after_seq");
    check_buffer();

    // Brightness with every segment lit
    for (int i = 0; i < DIGITS; i++) send(7'h7F);
    wait_ready("ready_after_fill");
    brightness = 4'd0;
    repeat (40) @(negedge clk);
    nz = 0;
    for (int i = 0; i < 64; i++) begin
      if (seg !== 7'h00) nz++;
      @(negedge clk);
    end
    check("pwm_dark_count", 8'(nz), 8'd0);
    brightness = 4'd8;
    repeat (40) @(negedge clk);
    nz = 0;
    for (int i = 0; i < 64; i++) begin
      if (seg !== 7'h00) nz++;
      @(negedge clk);
    end
    check("pwm_half_count", 8'(nz), 8'd32);
    brightness = 4'd15;
    repeat (40) @(negedge clk);

    // Clear together with an offered character, mid-wipe (step 3)
    send(7'h6D);
    repeat (3 * ANIM_DIV) @(negedge clk);
    clr            = 1'b1;
    bus.char_in    = 7'h77;
    bus.char_valid = 1'b1;
    @(negedge clk);
    clr            = 1'b0;
    bus.char_valid = 1'b0;
    for (int i = 0; i < DIGITS; i++) model_disp[i] = '0;
    check("clr_ready", 8'(bus.char_ready), 8'd1);
    check("clr_busy", 8'(busy), 8'd0);
    check_buffer();

    // Enable low blanks the outputs and drops ready
    send(7'h4F);
    wait_ready("ready_before_disable");
    en = 1'b0;
    #1;
    check("dis_ready", 8'(bus.char_ready), 8'd0);
    @(negedge clk);
    check("dis_seg", 8'(seg), 8'h00);
    check("dis_dig_sel", 8'(dig_sel), 8'h00);
    en = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-wipe (step 2)
    send(7'h5B);
    repeat (2 * ANIM_DIV) @(negedge clk);
    check("pre_reset_dig_sel_live", 8'(dig_sel != '0), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_seg", 8'(seg), 8'h00);
    check("async_rst_dig_sel", 8'(dig_sel), 8'h00);
    check("async_rst_busy", 8'(busy), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DIGITS; i++) model_disp[i] = '0;
    check("post_rst_busy", 8'(busy), 8'd0);
    check("post_rst_ready", 8'(bus.char_ready), 8'd1);
    check_buffer();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
